// File: rtl/vga_box_painter.sv
// Purpose: colours each pixel as a bouncing rectangle drawn over hcount[8:6] colour bars.
// Latency: rgb is registered one cycle after hcount/vcount/video_on; box moves 3 cycles after the frame tick.
// Backpressure: none; this is a free-running pixel stream that follows the timing generator.
module vga_box_painter #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int BOX_W = 32,
  parameter int BOX_H = 32,
  parameter int STEP = 2,
  parameter int X0 = 0,
  parameter int Y0 = 0,
  parameter logic [2:0] BOX_RGB = 3'b110
) (
  input  logic       clk,
  input  logic       ar,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       video_on,
  input  logic       pause,
  output logic       r,
  output logic       g,
  output logic       b,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       bounce,
  output logic [7:0] frame_cnt
);

  // 11-bit forms keep the edge/limit sums free of overflow.
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] BOX_W_W = 11'(BOX_W);
  localparam logic [10:0] BOX_H_W = 11'(BOX_H);
  localparam logic [10:0] X_MAX_W = 11'(H_ACT - BOX_W);
  localparam logic [10:0] Y_MAX_W = 11'(V_ACT - BOX_H);
  // 10-bit forms for the values actually loaded into the position registers.
  localparam logic [9:0]  STEP_P  = 10'(STEP);
  localparam logic [9:0]  X_MAX_P = 10'(H_ACT - BOX_W);
  localparam logic [9:0]  Y_MAX_P = 10'(V_ACT - BOX_H);
  localparam logic [9:0]  X0_P    = 10'(X0);
  localparam logic [9:0]  Y0_P    = 10'(Y0);
  localparam logic [9:0]  TICK_V  = 10'(V_ACT);

  typedef enum logic [1:0] {
    S_DRAW   = 2'd0,
    S_MOVE_X = 2'd1,
    S_MOVE_Y = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] box_x_q, box_x_d;
  logic [9:0] box_y_q, box_y_d;
  logic       dx_neg_q, dx_neg_d;   // 1 = moving left
  logic       dy_neg_q, dy_neg_d;   // 1 = moving up
  logic       pause_q, pause_d;     // pause as sampled in MOVE_X, reused in MOVE_Y
  logic       flag_q, flag_d;       // an axis reversed during this frame's update
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [2:0] rgb_q, rgb_d;

  logic        tick;
  logic [10:0] x_ext, y_ext, h_ext, v_ext;
  logic        in_box;

  assign tick  = (hcount == 10'd0) && (vcount == TICK_V);
  assign x_ext = {1'b0, box_x_q};
  assign y_ext = {1'b0, box_y_q};
  assign h_ext = {1'b0, hcount};
  assign v_ext = {1'b0, vcount};

  assign in_box = (h_ext >= x_ext) && (h_ext < x_ext + BOX_W_W) &&
                  (v_ext >= y_ext) && (v_ext < y_ext + BOX_H_W);

  // Pixel colour mux: blank outside active video, box over colour bars inside it.
  always_comb begin
    rgb_d = 3'b000;
    if (video_on) begin
      if (in_box) rgb_d = BOX_RGB;
      else        rgb_d = {hcount[8], hcount[7], hcount[6]};
    end
  end

  // Frame-update FSM: next state, clamped position moves, bounce flag and frame count.
  always_comb begin
    state_d     = state_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    pause_d     = pause_q;
    flag_d      = flag_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_DRAW: begin
        if (tick) state_d = S_MOVE_X;
      end
      S_MOVE_X: begin
        pause_d = pause;
        if (!pause) begin
          if (!dx_neg_q) begin
            if (x_ext + STEP_W >= X_MAX_W) begin
              box_x_d  = X_MAX_P;
              dx_neg_d = 1'b1;
              flag_d   = 1'b1;
            end else begin
              box_x_d = box_x_q + STEP_P;
            end
          end else begin
            if (x_ext <= STEP_W) begin
              box_x_d  = 10'd0;
              dx_neg_d = 1'b0;
              flag_d   = 1'b1;
            end else begin
              box_x_d = box_x_q - STEP_P;
            end
          end
        end
        state_d = S_MOVE_Y;
      end
      S_MOVE_Y: begin
        if (!pause_q) begin
          if (!dy_neg_q) begin
            if (y_ext + STEP_W >= Y_MAX_W) begin
              box_y_d  = Y_MAX_P;
              dy_neg_d = 1'b1;
              flag_d   = 1'b1;
            end else begin
              box_y_d = box_y_q + STEP_P;
            end
          end else begin
            if (y_ext <= STEP_W) begin
              box_y_d  = 10'd0;
              dy_neg_d = 1'b0;
              flag_d   = 1'b1;
            end else begin
              box_y_d = box_y_q - STEP_P;
            end
          end
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        flag_d      = 1'b0;
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = S_DRAW;
      end
      default: state_d = S_DRAW;
    endcase
  end

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (ar) begin
      state_q     <= S_DRAW;
      box_x_q     <= X0_P;
      box_y_q     <= Y0_P;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      pause_q     <= 1'b0;
      flag_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
      rgb_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      pause_q     <= pause_d;
      flag_q      <= flag_d;
      frame_cnt_q <= frame_cnt_d;
      rgb_q       <= rgb_d;
    end
  end

  // A single pulse per frame, decoded from registered state, however many axes reversed.
  assign bounce    = (state_q == S_DONE) && flag_q;
  assign {r, g, b} = rgb_q;
  assign box_x     = box_x_q;
  assign box_y     = box_y_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_box_painter.sv
// Bench for vga_box_painter: three instances with different start positions share one stimulus stream.
// Stimulus queues expected values tagged with the cycle they become valid; a monitor checks them.
// Instance 0 starts at (0,0), instance 1 at (606,0) near the right wall, instance 2 at (607,447) near a corner.
module tb_vga_box_painter;

  logic       clk = 1'b0;
  logic       ar;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       video_on;
  logic       pause;

  logic [2:0]      r_v, g_v, b_v, bn_v;
  logic [2:0][9:0] bx_v, by_v;
  logic [2:0][7:0] fc_v;

  always #20 clk = ~clk;

  vga_box_painter u0 (
    .clk(clk), .ar(ar), .hcount(hcount), .vcount(vcount), .video_on(video_on), .pause(pause),
    .r(r_v[0]), .g(g_v[0]), .b(b_v[0]), .box_x(bx_v[0]), .box_y(by_v[0]),
    .bounce(bn_v[0]), .frame_cnt(fc_v[0])
  );

  vga_box_painter #(.X0(606), .Y0(0)) u1 (
    .clk(clk), .ar(ar), .hcount(hcount), .vcount(vcount), .video_on(video_on), .pause(pause),
    .r(r_v[1]), .g(g_v[1]), .b(b_v[1]), .box_x(bx_v[1]), .box_y(by_v[1]),
    .bounce(bn_v[1]), .frame_cnt(fc_v[1])
  );

  vga_box_painter #(.X0(607), .Y0(447)) u2 (
    .clk(clk), .ar(ar), .hcount(hcount), .vcount(vcount), .video_on(video_on), .pause(pause),
    .r(r_v[2]), .g(g_v[2]), .b(b_v[2]), .box_x(bx_v[2]), .box_y(by_v[2]),
    .bounce(bn_v[2]), .frame_cnt(fc_v[2])
  );

  // Field codes for a scoreboard entry (selector = instance*16 + field).
  localparam int F_RGB  = 0;
  localparam int F_X    = 1;
  localparam int F_Y    = 2;
  localparam int F_FC   = 3;
  localparam int F_BNC  = 4;
  localparam int F_WIN  = 5;   // bounce cycles since the last mark
  localparam int F_MARK = 6;   // snapshot the bounce counter, no comparison

  typedef struct {
    int    cyc;
    int    sel;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   bcnt[3];
  int   bbase[3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_actual(input int sel);
    int k;
    int f;
    k = sel / 16;
    f = sel % 16;
    case (f)
      F_RGB:   return int'({r_v[k], g_v[k], b_v[k]});
      F_X:     return int'(bx_v[k]);
      F_Y:     return int'(by_v[k]);
      F_FC:    return int'(fc_v[k]);
      F_BNC:   return int'(bn_v[k]);
      F_WIN:   return bcnt[k] - bbase[k];
      default: return -1;
    endcase
  endfunction

  // Monitor: count bounce cycles, then retire every entry whose cycle has arrived.
  always @(negedge clk) begin
    int i;
    int act;
    for (int k = 0; k < 3; k++) if (bn_v[k]) bcnt[k] = bcnt[k] + 1;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        if (sb[i].sel % 16 == F_MARK) begin
          bbase[sb[i].sel / 16] = bcnt[sb[i].sel / 16];
        end else begin
          act = get_actual(sb[i].sel);
          n_checks = n_checks + 1;
          if (act != sb[i].exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
          end
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int inst, input int field, input int exp, input string nm, input int dly);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sel  = inst * 16 + field;
    e.exp  = exp;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    hcount   = 10'd700;
    vcount   = 10'd500;
    video_on = 1'b0;
  endtask

  task automatic mark_all();
    for (int k = 0; k < 3; k++) chk(k, F_MARK, 0, "mark", 0);
  endtask

  // One tick cycle then four blanking cycles: the update finishes within three.
  task automatic run_frame();
    hcount   = 10'd0;
    vcount   = 10'd480;
    video_on = 1'b0;
    step();
    hcount = 10'd1;
    repeat (4) step();
    idle_inputs();
  endtask

  task automatic chk_pos(input int inst, input int x, input int y, input string tag);
    chk(inst, F_X, x, {tag, "_x"}, 0);
    chk(inst, F_Y, y, {tag, "_y"}, 0);
  endtask

  task automatic chk_win(input int b0, input int b1, input int b2, input string tag);
    chk(0, F_WIN, b0, {tag, "_bounce0"}, 0);
    chk(1, F_WIN, b1, {tag, "_bounce1"}, 0);
    chk(2, F_WIN, b2, {tag, "_bounce2"}, 0);
  endtask

  // Pixel vectors: hcount, vcount, video_on, instance, expected {r,g,b}.
  typedef struct {
    int hc;
    int vc;
    int von;
    int inst;
    int exp;
  } pix_t;

  pix_t pix[13];

  initial begin
    pix[0]  = '{10,  10,  1, 0, 3'b110};  // inside box at origin
    pix[1]  = '{320, 100, 1, 0, 3'b101};  // bars: 320 has bits 8 and 6 set
    pix[2]  = '{256, 100, 1, 0, 3'b100};  // bars: bit 8 only
    pix[3]  = '{10,  10,  0, 0, 3'b000};  // blanking inside the box area
    pix[4]  = '{31,  31,  1, 0, 3'b110};  // last pixel of the box
    pix[5]  = '{32,  31,  1, 0, 3'b000};  // one past right edge
    pix[6]  = '{31,  32,  1, 0, 3'b000};  // one past bottom edge
    pix[7]  = '{200, 32,  1, 0, 3'b011};  // bars: bits 7 and 6
    pix[8]  = '{620, 5,   1, 1, 3'b110};  // inside box at x=606
    pix[9]  = '{620, 5,   1, 0, 3'b001};  // same pixel, bars for the origin box
    pix[10] = '{638, 5,   1, 1, 3'b001};  // one past right edge of box at 606
    pix[11] = '{605, 5,   1, 1, 3'b001};  // one before left edge of box at 606
    pix[12] = '{638, 478, 1, 2, 3'b110};  // bottom-right pixel of box at (607,447)

    ar    = 1'b1;
    pause = 1'b0;
    idle_inputs();
    bcnt  = '{0, 0, 0};
    bbase = '{0, 0, 0};

    // Reset state
    step();
    step();
    ar = 1'b0;
    chk(0, F_RGB, 0, "rst_rgb", 0);
    chk(0, F_FC,  0, "rst_fc",  0);
    chk(0, F_BNC, 0, "rst_bounce", 0);
    chk_pos(0, 0,   0,   "rst0");
    chk_pos(1, 606, 0,   "rst1");
    chk_pos(2, 607, 447, "rst2");

    // Pixel mux: each vector is registered on the next edge.
    for (int i = 0; i < 13; i++) begin
      hcount   = 10'(pix[i].hc);
      vcount   = 10'(pix[i].vc);
      video_on = pix[i].von[0];
      chk(pix[i].inst, F_RGB, pix[i].exp, $sformatf("pix%0d", i), 1);
      step();
    end
    idle_inputs();
    step();

    // Frame 1: right wall on u1, corner on u2 (single pulse for both axes).
    mark_all();
    run_frame();
    chk_pos(0, 2,   2,   "f1_u0");
    chk_pos(1, 608, 2,   "f1_u1");
    chk_pos(2, 608, 448, "f1_u2");
    chk(0, F_FC, 1, "f1_fc", 0);
    chk(0, F_BNC, 0, "f1_bounce_idle", 0);
    chk_win(0, 1, 1, "f1");

    // Frame 2: reversed axes move back by one step.
    step();
    mark_all();
    run_frame();
    chk_pos(0, 4,   4,   "f2_u0");
    chk_pos(1, 606, 4,   "f2_u1");
    chk_pos(2, 606, 446, "f2_u2");
    chk(0, F_FC, 2, "f2_fc", 0);
    chk_win(0, 0, 0, "f2");

    // Pause across three frames: positions frozen, frames still counted.
    pause = 1'b1;
    step();
    mark_all();
    repeat (3) run_frame();
    chk_pos(0, 4,   4,   "pause_u0");
    chk_pos(1, 606, 4,   "pause_u1");
    chk_pos(2, 606, 446, "pause_u2");
    chk(0, F_FC, 5, "pause_fc", 0);
    chk(2, F_FC, 5, "pause_fc2", 0);
    chk_win(0, 0, 0, "pause");
    pause = 1'b0;
    step();

    // Reset in MOVE_X, the cycle after the tick.
    hcount   = 10'd0;
    vcount   = 10'd480;
    video_on = 1'b0;
    step();
    ar     = 1'b1;
    hcount = 10'd1;
    step();
    ar = 1'b0;
    idle_inputs();
    chk(0, F_RGB, 0, "midrst_rgb", 0);
    chk(0, F_FC,  0, "midrst_fc",  0);
    chk(0, F_BNC, 0, "midrst_bounce", 0);
    chk_pos(0, 0,   0,   "midrst_u0");
    chk_pos(1, 606, 0,   "midrst_u1");
    chk_pos(2, 607, 447, "midrst_u2");
    step();
    mark_all();
    run_frame();
    chk_pos(0, 2,   2,   "post_u0");
    chk_pos(1, 608, 2,   "post_u1");
    chk_pos(2, 608, 448, "post_u2");
    chk(0, F_FC, 1, "post_fc", 0);
    chk_win(0, 1, 1, "post");

    // Drain the scoreboard with a bounded wait.
    begin
      int w;
      w = 0;
      while (sb.size() > 0 && w < 50) begin
        step();
        w++;
      end
    end
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      n_fail = n_fail + 1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
